// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, status
// codes, stage enable vectors and instruction-code constants.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4,
        STAT_TMO = 3'd5
    } stat_t;

    // One-hot stage enable vectors: {pc, wb, memory, execute, decode, fetch}
    localparam logic [5:0] EN_NONE    = 6'b000000;
    localparam logic [5:0] EN_FETCH   = 6'b000001;
    localparam logic [5:0] EN_DECODE  = 6'b000010;
    localparam logic [5:0] EN_EXECUTE = 6'b000100;
    localparam logic [5:0] EN_MEMORY  = 6'b001000;
    localparam logic [5:0] EN_WB      = 6'b010000;
    localparam logic [5:0] EN_PC      = 6'b100000;

    localparam logic [3:0] ICODE_HALT = 4'h0;

    // Instructions that touch data memory go through the MEMORY stage.
    function automatic logic uses_memory(input logic [3:0] code);
        return (code == 4'h4) || (code == 4'h5) || (code == 4'h8) ||
               (code == 4'h9) || (code == 4'hA) || (code == 4'hB);
    endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Stage handshake bundle: enables out of the sequencer, done strobes and
// fetch/memory side information back into it.
interface seq_controller_if;
    logic       fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en;
    logic       fetch_done, decode_done, execute_done, memory_done, wb_done, pc_done;
    logic [3:0] icode;
    logic       iv;
    logic       ime;
    logic       dmem_error;

    modport master (
        output fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
        input  fetch_done, decode_done, execute_done, memory_done, wb_done, pc_done,
        input  icode, iv, ime, dmem_error
    );

    modport slave (
        input  fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
        output fetch_done, decode_done, execute_done, memory_done, wb_done, pc_done,
        output icode, iv, ime, dmem_error
    );
endinterface

// File: rtl/stage_watchdog.sv
// Counts consecutive cycles a stage is active without completing and flags
// expiry on the cycle the count reaches TIMEOUT.
module stage_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    // Count active cycles; restart whenever the stage completes or goes idle.
    always_ff @(posedge clk) begin
        if (rst || clear || !active) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Current cycle is the TIMEOUT-th one in this stage.
    assign expired = active && !clear && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle instruction sequencer: steps one-hot stage enables through
// FETCH..PCUPD, halts on errors or stage timeouts.
// Optional feature macro: SEQ_PERF_CNT_EN enables saturating cycle and
// instruction counters; without it the counter ports read zero.
module seq_controller
    import seq_pkg::*;
#(
    parameter int STAGE_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    seq_controller_if.master stg,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    state_t     state_reg;
    logic [5:0] en_reg;
    stat_t      stat_reg;
    logic       halted_reg;
    logic [3:0] icode_reg;
    logic [5:0] done_vec;
    logic       stage_done;
    logic       stage_active;
    logic       wd_expired;

    assign done_vec     = {stg.pc_done, stg.wb_done, stg.memory_done,
                           stg.execute_done, stg.decode_done, stg.fetch_done};
    // Only the done strobe of the currently enabled stage matters.
    assign stage_done   = |(en_reg & done_vec);
    assign stage_active = |en_reg;

    stage_watchdog #(.TIMEOUT(STAGE_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (stage_done),
        .active  (stage_active),
        .expired (wd_expired)
    );

    // Sequencer state, registered enables and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            en_reg     <= EN_NONE;
            stat_reg   <= STAT_AOK;
            halted_reg <= 1'b0;
            icode_reg  <= 4'h0;
        end else if (wd_expired && !stage_done) begin
            state_reg  <= ST_HALT;
            en_reg     <= EN_NONE;
            stat_reg   <= STAT_TMO;
            halted_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                        en_reg    <= EN_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (stg.fetch_done) begin
                        icode_reg <= stg.icode;
                        if (stg.ime || !stg.iv || (stg.icode == ICODE_HALT)) begin
                            state_reg  <= ST_HALT;
                            en_reg     <= EN_NONE;
                            halted_reg <= 1'b1;
                            stat_reg   <= stg.ime ? STAT_ADR :
                                          (!stg.iv ? STAT_INS : STAT_HLT);
                        end else begin
                            state_reg <= ST_DECODE;
                            en_reg    <= EN_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    if (stg.decode_done) begin
                        state_reg <= ST_EXECUTE;
                        en_reg    <= EN_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (stg.execute_done) begin
                        if (uses_memory(icode_reg)) begin
                            state_reg <= ST_MEMORY;
                            en_reg    <= EN_MEMORY;
                        end else begin
                            state_reg <= ST_WRITEBACK;
                            en_reg    <= EN_WB;
                        end
                    end
                end
                ST_MEMORY: begin
                    if (stg.memory_done) begin
                        if (stg.dmem_error) begin
                            state_reg  <= ST_HALT;
                            en_reg     <= EN_NONE;
                            stat_reg   <= STAT_ADR;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_WRITEBACK;
                            en_reg    <= EN_WB;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (stg.wb_done) begin
                        state_reg <= ST_PCUPD;
                        en_reg    <= EN_PC;
                    end
                end
                ST_PCUPD: begin
                    if (stg.pc_done) begin
                        state_reg <= ST_FETCH;
                        en_reg    <= EN_FETCH;
                    end
                end
                default: begin
                    // HALT is absorbing until reset.
                    state_reg <= ST_HALT;
                    en_reg    <= EN_NONE;
                end
            endcase
        end
    end

    assign stg.fetch_en   = en_reg[0];
    assign stg.decode_en  = en_reg[1];
    assign stg.execute_en = en_reg[2];
    assign stg.memory_en  = en_reg[3];
    assign stg.wb_en      = en_reg[4];
    assign stg.pc_en      = en_reg[5];
    assign stat           = stat_reg;
    assign busy           = stage_active;
    assign halted         = halted_reg;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instr_cnt_reg;

    // Saturating counts of busy cycles and retired instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            if (stage_active && (cycle_cnt_reg != '1)) begin
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            end
            if ((state_reg == ST_PCUPD) && stg.pc_done && !wd_expired
                && (instr_cnt_reg != '1)) begin
                instr_cnt_reg <= instr_cnt_reg + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign instr_cnt = instr_cnt_reg;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have parameter STAGE_TIMEOUT, default 16, max cycles a stage may hold its enable without done.
REQ-002 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin execution; sampled only in IDLE.
REQ-006 SHALL have ports fetch_done, decode_done, execute_done, memory_done, wb_done, pc_done  input  1 each  stage-complete strobes.
REQ-007 SHALL have port icode  input  4  fetched instruction code, valid with fetch_done.
REQ-008 SHALL have ports iv, ime  input  1 each  instruction valid / instruction-memory error, valid with fetch_done.
REQ-009 SHALL have port dmem_error  input  1  data-memory error, valid with memory_done.
REQ-010 SHALL have ports fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  output  1 each  registered stage enables, at most one high.
REQ-011 SHALL have port stat  output  3  status: AOK=1, HLT=2, ADR=3, INS=4, TMO=5.
REQ-012 SHALL have ports busy, halted  output  1 each.
REQ-013 SHALL have ports cycle_cnt, instr_cnt  output  CNT_W each.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
REQ-015 SHALL hold the enable of the current stage state high for every cycle in that state; all enables low in IDLE and HALT.
REQ-016 SHALL move IDLE->FETCH on the edge where start=1; FETCH enable high the following cycle.
REQ-017 SHALL advance to the next stage on the edge where the current stage's done=1; done inputs of other stages ignored.
REQ-018 SHALL latch icode on fetch_done.
REQ-019 SHALL on fetch_done evaluate with priority ime=1 -> HALT, stat=ADR; iv=0 -> HALT, stat=INS; icode=0 -> HALT, stat=HLT; else -> DECODE.
REQ-020 SHALL go EXECUTE->MEMORY only for latched icode in {4,5,8,9,A,B}; otherwise EXECUTE->WRITEBACK.
REQ-021 SHALL on memory_done with dmem_error=1 go to HALT, stat=ADR, skipping WRITEBACK and PCUPD.
REQ-022 SHALL go PCUPD->FETCH on pc_done (back-to-back instructions, no IDLE gap).
REQ-023 SHALL count cycles in each stage state; when the count reaches STAGE_TIMEOUT without done, go to HALT, stat=TMO; count clears on every state change.
REQ-024 SHALL hold stat=AOK while not halted; HALT is absorbing until rst; start ignored outside IDLE.
REQ-025 SHALL drive busy=1 in any stage state, halted=1 only in HALT.

Reset
REQ-026 SHALL on rst=1 at a clock edge enter IDLE, clear all enables, busy=0, halted=0, stat=AOK, counters=0, latched icode=0, regardless of state, including mid-instruction.
REQ-027 SHALL give rst priority over start and all done inputs in the same cycle.

Configuration
REQ-028 SHALL honour macro SEQ_PERF_CNT_EN.
REQ-029 SHALL with SEQ_PERF_CNT_EN defined increment cycle_cnt every cycle in a stage state and instr_cnt on each pc_done, both saturating at all-ones.
REQ-030 SHALL without SEQ_PERF_CNT_EN keep cycle_cnt and instr_cnt ports, tied to zero, with no counter logic.

Structure
REQ-031 SHALL take state encoding, stat codes and icode constants from shared package seq_pkg.
REQ-032 SHALL place the stage timeout counter in sub-module stage_watchdog (inputs clk, rst, clear, active; output expired).

Verification
REQ-033 SHALL cover: rst, start=1, each done one cycle after its enable, icode=6 -> enables FETCH,DECODE,EXECUTE,WRITEBACK,PCUPD in order, MEMORY skipped, back in FETCH, instr_cnt=1.
REQ-034 SHALL cover: icode=5 with dmem_error=1 on memory_done -> HALT next cycle, stat=3, wb_en and pc_en never asserted, halted=1 until rst.
REQ-035 SHALL cover: fetch_done with icode=0 -> stat=2; separately iv=0 -> stat=4; ime=1 and iv=0 together -> stat=3.
REQ-036 SHALL cover: decode_done withheld 16 cycles (default) -> HALT, stat=5; decode_done on cycle 15 -> DECODE->EXECUTE, no timeout.
REQ-037 SHALL cover: rst asserted while execute_en=1 -> next cycle IDLE, all enables 0, stat=1, counters 0; start in HALT ignored.
